// File: rtl/handshake_pkg.sv
// Shared constants and elaboration helpers for the VALID/READY handshake block family.
package handshake_pkg;

  localparam int unsigned HS_WIDTH_DEFAULT = 8;
  localparam int unsigned HS_DEPTH_DEFAULT = 2;

  // Smallest r with 2**r >= v; usable in parameter expressions.
  function automatic int unsigned hs_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit hs_depth_legal(input int unsigned d);
    return (d >= 2) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/handshake_ram.sv
// WIDTH x DEPTH register array: synchronous write, asynchronous read, synchronous clear.
module handshake_ram
  import handshake_pkg::*;
#(
  parameter int unsigned WIDTH = HS_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = HS_DEPTH_DEFAULT,
  localparam int unsigned AW   = hs_clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/handshake_fifo_slice.sv
// Elastic VALID/READY buffer of DEPTH words; READY_UP/VALID_DOWN are decoded from the
// registered occupancy only, so no input reaches any output combinationally.
module handshake_fifo_slice
  import handshake_pkg::*;
#(
  parameter int unsigned WIDTH = HS_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = HS_DEPTH_DEFAULT,
  localparam int unsigned PTR_W = hs_clog2(DEPTH),
  localparam int unsigned CNT_W = hs_clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             VALID_UP,
  output logic             READY_UP,
  input  logic [WIDTH-1:0] DATA_UP,
  output logic             VALID_DOWN,
  input  logic             READY_DOWN,
  output logic [WIDTH-1:0] DATA_DOWN,
  output logic [CNT_W-1:0] COUNT
);

  if (!hs_depth_legal(DEPTH)) begin : g_depth_check
    $error("handshake_fifo_slice: DEPTH must be a power of two and >= 2");
  end

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             push, pop;

  assign READY_UP   = (count_q != FULL);
  assign VALID_DOWN = (count_q != '0);
  assign COUNT      = count_q;

  // A flush cycle swallows any handshake that would otherwise complete.
  assign push = VALID_UP && READY_UP && !FLUSH;
  assign pop  = VALID_DOWN && READY_DOWN && !FLUSH;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (FLUSH) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  handshake_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (DATA_UP),
    .raddr_i (rd_ptr_q),
    .rdata_o (DATA_DOWN)
  );

endmodule
